vmem_sequencer: RTL and testbench

// - Serialises vector memory ops (VLW/VSW) onto the single scalar data-memory port, one lane per access.
// - Sits between the per-lane vector ALUs (which compute the lane addresses) and the dmem port.
// - Stalls the pipeline until every active lane has been serviced.
// - Presents gathered load data to the vector register write-back.

---
 rtl/vmem_sequencer_pkg.sv | 13 +
 rtl/vmem_sequencer_if.sv | 17 +
 rtl/vmem_sequencer_lane_select.sv | 27 ++
 rtl/vmem_sequencer.sv | 154 +++++++++++++++
 tb/tb_vmem_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_sequencer_pkg.sv
// Shared types for the vector memory sequencer: word type, lane mask and FSM states.
// Default lane count lives here so the interface, sub-module and top agree.
package vmem_sequencer_pkg;

  localparam int VM_THREADS = 4;
  localparam int VM_LANE_W  = (VM_THREADS > 1) ? $clog2(VM_THREADS) : 1;

  typedef logic [31:0]           word_t;
  typedef logic [VM_THREADS-1:0] lane_mask_t;

  typedef enum logic [1:0] {VM_IDLE, VM_ACCESS, VM_DONE} vmem_state_t;

endpackage

// File: rtl/vmem_sequencer_if.sv
// Scalar data-memory port driven by the vector memory sequencer.
// master = sequencer side, slave = memory side.
interface vmem_sequencer_if;
  import vmem_sequencer_pkg::*;

  logic  mem_ren;
  logic  mem_wen;
  word_t mem_addr;
  word_t mem_store;
  word_t mem_load;
  logic  mem_wait;

  modport master (output mem_ren, mem_wen, mem_addr, mem_store,
                  input  mem_load, mem_wait);
  modport slave  (input  mem_ren, mem_wen, mem_addr, mem_store,
                  output mem_load, mem_wait);
endinterface

// File: rtl/vmem_sequencer_lane_select.sv
// Priority encoder: lowest set bit of mask, either from bit 0 (first=1)
// or strictly above cur (first=0). none_left flags an empty search.
module vmem_sequencer_lane_select #(
  parameter int THREADS = 4,
  parameter int LANE_W  = 2
) (
  input  logic [THREADS-1:0] mask,
  input  logic [LANE_W-1:0]  cur,
  input  logic               first,
  output logic [LANE_W-1:0]  next_lane,
  output logic               none_left
);

  // NOTE: every output gets a default before the loop, so no path can infer a latch.
  always_comb begin
    next_lane = '0;
    none_left = 1'b1;
    // Descending scan: the last hit written is the lowest eligible lane.
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (mask[i] && (first || i > int'(cur))) begin
        next_lane = LANE_W'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vmem_sequencer.sv
// Serialises VLW/VSW lanes onto the scalar dmem port, gathering load data per lane.
// Optional `VMEM_COALESCE_EN: consecutive load lanes sharing an address reuse one access.
module vmem_sequencer
  import vmem_sequencer_pkg::*;
#(
  parameter int THREADS = VM_THREADS,
  parameter int LANE_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_load,
  input  logic                      is_store,
  input  logic [THREADS-1:0]        lane_mask,
  input  word_t [THREADS-1:0]       lane_addr,
  input  word_t [THREADS-1:0]       lane_store,
  vmem_sequencer_if.master          mem,
  output logic                      stall,
  output logic                      done,
  output word_t [THREADS-1:0]       vload_data,
  output logic [THREADS-1:0]        vload_wen,
  output logic                      err
);

  vmem_state_t          state_q, state_d;
  logic                 load_q;
  logic [THREADS-1:0]   mask_q, pend_q, pend_d, pend_clr, merge_mask, sel_mask;
  logic [LANE_W-1:0]    cur_q, cur_d, sel_lane;
  logic                 sel_first, sel_none, capture, valid_op;
  word_t [THREADS-1:0]  addr_q, store_q, data_q, data_d;
`ifdef VMEM_COALESCE_EN
  logic                 merging;
`endif

  assign valid_op = is_load ^ is_store;

  // Pending lanes once the current access retires, plus any same-address load lanes folded into it.
  always_comb begin
    pend_clr        = pend_q;
    pend_clr[cur_q] = 1'b0;
    merge_mask      = '0;
`ifdef VMEM_COALESCE_EN
    merging = load_q;
    for (int j = 0; j < THREADS; j++) begin
      if (merging && j > int'(cur_q) && pend_clr[j]) begin
        if (addr_q[j] == addr_q[cur_q]) begin
          merge_mask[j] = 1'b1;
          pend_clr[j]   = 1'b0;
        end else begin
          merging = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    if (state_q == VM_IDLE) begin
      sel_mask  = lane_mask;
      sel_first = 1'b1;
    end else begin
      sel_mask  = pend_clr;
      sel_first = 1'b0;
    end
  end

  vmem_sequencer_lane_select #(.THREADS(THREADS), .LANE_W(LANE_W)) u_lane_select (
    .mask      (sel_mask),
    .cur       (cur_q),
    .first     (sel_first),
    .next_lane (sel_lane),
    .none_left (sel_none)
  );

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    cur_d         = cur_q;
    data_d        = data_q;
    capture       = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    vload_data    = '0;
    vload_wen     = '0;
    mem.mem_ren   = 1'b0;
    mem.mem_wen   = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_store = '0;
    unique case (state_q)
      VM_IDLE: begin
        if (start && valid_op) begin
          capture = 1'b1;
          stall   = 1'b1;
          pend_d  = lane_mask;
          cur_d   = sel_lane;
          data_d  = '0;
          state_d = sel_none ? VM_DONE : VM_ACCESS;
        end else if (start) begin
          err = 1'b1;
        end
      end
      VM_ACCESS: begin
        stall         = 1'b1;
        mem.mem_ren   = load_q;
        mem.mem_wen   = ~load_q;
        mem.mem_addr  = addr_q[cur_q];
        mem.mem_store = store_q[cur_q];
        if (!mem.mem_wait) begin
          if (load_q) data_d[cur_q] = mem.mem_load;
          for (int j = 0; j < THREADS; j++) begin
            if (merge_mask[j]) data_d[j] = mem.mem_load;
          end
          pend_d = pend_clr;
          cur_d  = sel_lane;
          if (sel_none) state_d = VM_DONE;
        end
      end
      VM_DONE: begin
        done       = 1'b1;
        vload_data = data_q;
        vload_wen  = load_q ? mask_q : '0;
        state_d    = VM_IDLE;
      end
      default: state_d = VM_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the small gather buffer is reset too, so inactive lanes read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VM_IDLE;
      load_q  <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      cur_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      data_q  <= data_d;
      if (capture) begin
        load_q  <= is_load;
        mask_q  <= lane_mask;
        addr_q  <= lane_addr;
        store_q <= lane_store;
      end
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Scoreboard bench for vmem_sequencer: expected accesses and done events are queued at issue
// and retired by monitors. Honours `VMEM_COALESCE_EN when expecting merged load lanes.
module tb_vmem_sequencer;
  import vmem_sequencer_pkg::*;

  typedef struct {
    logic  wen;
    word_t addr;
    word_t wdata;
  } acc_t;

  typedef struct {
    int                 cyc;
    word_t [3:0]        data;
    logic  [3:0]        wen;
  } done_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, is_load, is_store;
  logic  [3:0]   lane_mask;
  word_t [3:0]   lane_addr, lane_store;
  logic          stall, done, err;
  word_t [3:0]   vload_data;
  logic  [3:0]   vload_wen;

  vmem_sequencer_if mif ();

  vmem_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .lane_mask  (lane_mask),
    .lane_addr  (lane_addr),
    .lane_store (lane_store),
    .mem        (mif),
    .stall      (stall),
    .done       (done),
    .vload_data (vload_data),
    .vload_wen  (vload_wen),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign mif.mem_load = mif.mem_addr + 32'd1;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    wait_per = 0;
  int    wcnt     = 0;
  logic  have_prev = 1'b0;
  acc_t  prev_req;
  acc_t  acc_q[$];
  done_t done_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: inserts wait_per wait cycles per access and retires completed accesses.
  always @(negedge clk) begin
    if (rst || !(mif.mem_ren || mif.mem_wen)) begin
      mif.mem_wait = 1'b0;
      wcnt = 0;
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("hold_addr",  mif.mem_addr,  prev_req.addr);
        check("hold_store", mif.mem_store, prev_req.wdata);
        check("hold_wen",   32'(mif.mem_wen), 32'(prev_req.wen));
      end
      if (wcnt < wait_per) begin
        mif.mem_wait   = 1'b1;
        wcnt++;
        have_prev      = 1'b1;
        prev_req.wen   = mif.mem_wen;
        prev_req.addr  = mif.mem_addr;
        prev_req.wdata = mif.mem_store;
      end else begin
        mif.mem_wait = 1'b0;
        wcnt = 0;
        have_prev = 1'b0;
        if (acc_q.size() == 0) begin
          check("unexpected_access", mif.mem_addr, 32'hFFFF_FFFF);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          check("acc_ren",  32'(mif.mem_ren), 32'(!e.wen));
          check("acc_wen",  32'(mif.mem_wen), 32'(e.wen));
          check("acc_addr", mif.mem_addr, e.addr);
          if (e.wen) check("acc_wdata", mif.mem_store, e.wdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        for (int i = 0; i < 4; i++) check($sformatf("vload_data%0d", i), vload_data[i], d.data[i]);
        check("vload_wen", 32'(vload_wen), 32'(d.wen));
      end
      done_cnt++;
    end
  end

  // Reference model: ascending lane order, optional same-address merging of loads.
  task automatic expect_op(input logic ld, input logic [3:0] msk, input word_t [3:0] ad,
                           input word_t [3:0] st, input int s, input int wp);
    done_t d;
    int    cycles = 0;
    logic  have_last = 1'b0;
    word_t last_addr = '0;
    d.data = '0;
    d.wen  = ld ? msk : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (msk[i]) begin
        if (ld) d.data[i] = ad[i] + 32'd1;
`ifdef VMEM_COALESCE_EN
        if (ld && have_last && ad[i] == last_addr) continue;
`endif
        acc_q.push_back('{wen: !ld, addr: ad[i], wdata: st[i]});
        have_last = 1'b1;
        last_addr = ad[i];
        cycles += wp + 1;
      end
    end
    d.cyc = s + cycles + 1;
    done_q.push_back(d);
  endtask

  task automatic issue(input logic ld, input logic stv, input logic [3:0] msk, output int s);
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; is_store = stv; lane_mask = msk;
    s = cyc;
    @(negedge clk);
    check("stall_start", 32'(stall), 32'(ld ^ stv));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge clk); #1;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  int s;

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    lane_mask = '0; lane_addr = '0; lane_store = '0;
    mif.mem_wait = 1'b0;
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_ren",   32'(mif.mem_ren), 32'd0);
    check("rst_wen",   32'(mif.mem_wen), 32'd0);
    check("rst_vwen",  32'(vload_wen),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // VLW, all lanes, no wait; a VSW start during ACCESS must be ignored.
    wait_per = 0;
    lane_addr  = '{32'h10C, 32'h108, 32'h104, 32'h100};
    lane_store = '{32'h0, 32'h0, 32'h0, 32'h0};
    expect_op(1'b1, 4'b1111, lane_addr, lane_store, cyc + 1, 0);
    issue(1'b1, 1'b0, 4'b1111, s);
    start = 1'b1; is_load = 1'b0; is_store = 1'b1;
    @(negedge clk);
    check("stall_access", 32'(stall), 32'd1);
    check("err_access",   32'(err),   32'd0);
    @(posedge clk); #1 start = 1'b0;
    wait_done(1, 20);

    // VSW, lanes 0 and 2, three wait cycles per access.
    wait_per   = 3;
    lane_addr  = '{32'h30C, 32'h308, 32'h304, 32'h300};
    lane_store = '{32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    expect_op(1'b0, 4'b0101, lane_addr, lane_store, cyc + 1, 3);
    issue(1'b0, 1'b1, 4'b0101, s);
    wait_done(2, 30);

    // Empty mask: straight to DONE, stall only in the start cycle.
    wait_per = 0;
    expect_op(1'b1, 4'b0000, lane_addr, lane_store, cyc + 1, 0);
    issue(1'b1, 1'b0, 4'b0000, s);
    @(negedge clk);
    check("stall_done_empty", 32'(stall), 32'd0);
    check("done_empty",       32'(done),  32'd1);
    wait_done(3, 5);

    // Illegal op encodings raise err without stalling.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; is_load = (k == 0); is_store = (k == 0); lane_mask = 4'b1111;
      @(negedge clk);
      check("err_pulse", 32'(err),   32'd1);
      check("err_stall", 32'(stall), 32'd0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("err_clear", 32'(err), 32'd0);
    end

    // Reset mid-ACCESS while memory is waiting.
    wait_per = 3;
    lane_addr = '{32'h50C, 32'h508, 32'h504, 32'h500};
    expect_op(1'b1, 4'b0011, lane_addr, lane_store, cyc + 1, 3);
    issue(1'b1, 1'b0, 4'b0011, s);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_ren",   32'(mif.mem_ren), 32'd0);
    check("rst_mid_stall", 32'(stall),       32'd0);
    acc_q.delete();
    done_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    wait_per = 1;
    lane_addr = '{32'h40C, 32'h408, 32'h404, 32'h400};
    expect_op(1'b1, 4'b1010, lane_addr, lane_store, cyc + 1, 1);
    issue(1'b1, 1'b0, 4'b1010, s);
    wait_done(done_cnt + 1, 20);

    // All lanes hit the same address.
    wait_per = 0;
    lane_addr = '{32'h200, 32'h200, 32'h200, 32'h200};
    expect_op(1'b1, 4'b1111, lane_addr, lane_store, cyc + 1, 0);
    issue(1'b1, 1'b0, 4'b1111, s);
    wait_done(done_cnt + 1, 20);

    repeat (3) @(negedge clk);
    check("acc_q_empty",  acc_q.size(),  32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
